// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared elaboration helpers for the pipelined mux tree
package mux_pkg;

    // Only complete 4-ary trees are supported.
    function automatic bit n_in_legal(input int n);
        return (n == 4) || (n == 16) || (n == 64);
    endfunction

    // Number of 4:1 levels needed to reduce n channels to one.
    function automatic int log4(input int n);
        int d;
        d = 0;
        for (int v = n; v > 1; v = v / 4) begin
            d++;
        end
        return d;
    endfunction

    // Flat position of the first node of level lvl (level 0 holds n/4 nodes,
    // level 1 holds n/16, ...); level_base(n, log4(n)) is the total node count.
    function automatic int level_base(input int n, input int lvl);
        return (n - (n >> (2 * lvl))) / 3;
    endfunction

endpackage

// File: rtl/mux4_stage.sv
// rtl/mux4_stage.sv - one registered 4:1 tree node with valid/index side-band
// Ports: clk, rst_n (async, active low), en (advance), in_data (4 packed
// channels), in_valid, in_idx (full channel index), out_data/out_valid/out_idx.
// LVL picks which select pair of in_idx steers this node.
module mux4_stage
    import mux_pkg::*;
#(
    parameter int W   = 8,
    parameter int SW  = 4,
    parameter int LVL = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [4*W-1:0] in_data,
    input  logic          in_valid,
    input  logic [SW-1:0] in_idx,
    output logic [W-1:0]  out_data,
    output logic          out_valid,
    output logic [SW-1:0] out_idx
);

    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [1:0]    pick;

    // The full index travels with the sample, so its upper bits double as
    // the remaining select for the downstream levels.
    assign pick = in_idx[2*LVL +: 2];

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        if (en) begin
            valid_d = in_valid;
            idx_d   = in_idx;
            case (pick)
                2'd0:    data_d = in_data[0*W +: W];
                2'd1:    data_d = in_data[1*W +: W];
                2'd2:    data_d = in_data[2*W +: W];
                default: data_d = in_data[3*W +: W];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_idx   = idx_q;

endmodule

// File: rtl/pipelined_mux_tree.sv
// rtl/pipelined_mux_tree.sv - N_IN:1 channel mux built as a pipelined 4:1 tree
// Ports: clk, rst_n (async, active low), en (advance/freeze), in_data (N_IN
// packed W-bit channels), in_valid, sel (manual select), scan_mode
// (round-robin select), out_data/out_valid/out_ch. Latency is LAT = log4(N_IN).
// Macro MUX_SCAN_EN: builds the round-robin scan counter; without it
// scan_mode is ignored and sel always steers.
module pipelined_mux_tree
    import mux_pkg::*;
#(
    parameter int  N_IN = 16,
    parameter int  W    = 8,
    localparam int SW   = $clog2(N_IN),
    localparam int LAT  = log4(N_IN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [N_IN*W-1:0] in_data,
    input  logic            in_valid,
    input  logic [SW-1:0]   sel,
    input  logic            scan_mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    output logic [SW-1:0]   out_ch
);

    localparam int TOT = level_base(N_IN, LAT);

    if (!n_in_legal(N_IN)) begin : g_bad_n_in
        $error("pipelined_mux_tree: N_IN must be 4, 16 or 64");
    end

    logic [SW-1:0] eff_sel;

`ifdef MUX_SCAN_EN
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;

    // Power-of-two N_IN lets the natural SW-bit overflow provide the wrap.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        if (en && in_valid && scan_mode) begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
        end
    end

    assign eff_sel = scan_mode ? scan_cnt_q : sel;
`else
    wire unused_scan_mode = scan_mode;
    assign eff_sel = sel;
`endif

    // All node outputs share one flat bus, level after level; the four
    // children of a node are always contiguous in it.
    logic [TOT*W-1:0]  node_data;
    logic [LAT-1:0]    lvl_valid;
    logic [LAT*SW-1:0] lvl_idx;

    for (genvar l = 0; l < LAT; l++) begin : g_lvl
        localparam int NODES = N_IN >> (2 * (l + 1));
        for (genvar n = 0; n < NODES; n++) begin : g_node
            logic [4*W-1:0] src_data;
            logic           src_valid;
            logic [SW-1:0]  src_idx;
            logic           node_valid;
            logic [SW-1:0]  node_idx;

            if (l == 0) begin : g_src_in
                assign src_data  = in_data[n*4*W +: 4*W];
                assign src_valid = in_valid;
                assign src_idx   = eff_sel;
            end else begin : g_src_tree
                assign src_data  = node_data[(level_base(N_IN, l-1) + 4*n)*W +: 4*W];
                assign src_valid = lvl_valid[l-1];
                assign src_idx   = lvl_idx[(l-1)*SW +: SW];
            end

            mux4_stage #(
                .W  (W),
                .SW (SW),
                .LVL(l)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en),
                .in_data  (src_data),
                .in_valid (src_valid),
                .in_idx   (src_idx),
                .out_data (node_data[(level_base(N_IN, l) + n)*W +: W]),
                .out_valid(node_valid),
                .out_idx  (node_idx)
            );

            // Every node of a level carries the same side-band; node 0's copy
            // feeds the next level.
            if (n == 0) begin : g_side
                assign lvl_valid[l]          = node_valid;
                assign lvl_idx[l*SW +: SW]   = node_idx;
            end else begin : g_side_dup
                wire unused_side = ^{node_valid, node_idx};
            end
        end
    end

    assign out_data  = node_data[(TOT-1)*W +: W];
    assign out_valid = lvl_valid[LAT-1];
    assign out_ch    = lvl_idx[(LAT-1)*SW +: SW];

endmodule

// File: doc/pipelined_mux_tree.md
PIPELINED_MUX_TREE -- requirements
Module: pipelined_mux_tree

Interface
REQ-001 The block SHALL have parameter N_IN, default 16, meaning the input channel count; legal values are 4, 16 and 64.
REQ-002 The block SHALL have parameter W, default 8, meaning the channel data width in bits (1..64).
REQ-003 The block SHALL derive localparams SW = log2(N_IN) (select width) and LAT = log4(N_IN) (pipeline depth).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  pipeline advance enable; 0 freezes all state.
REQ-007 in_data  input  N_IN*W  packed channels; channel k occupies bits [k*W+W-1 : k*W].
REQ-008 in_valid  input  1  in_data/sel qualify a sample this cycle.
REQ-009 sel  input  SW  channel select used in manual mode.
REQ-010 scan_mode  input  1  1 = internal round-robin select, 0 = manual select.
REQ-011 out_data  output  W  selected channel data.
REQ-012 out_valid  output  1  out_data/out_ch qualified.
REQ-013 out_ch  output  SW  channel index that produced out_data.

Function
REQ-014 The block SHALL form a tree of 4:1 stages; stage s consumes select bits [2s+1:2s], so the LSB pair is resolved first.
REQ-015 Each stage SHALL register its data, its valid bit and the remaining upper select bits, plus the full channel index.
REQ-016 With en=1 every cycle, a sample accepted at edge t SHALL appear on out_data/out_valid/out_ch after exactly LAT edges (edge t+LAT).
REQ-017 When en=0 no register SHALL change, including the scan counter, and the outputs SHALL hold their values.
REQ-018 When in_valid=0 and en=1, a bubble (valid=0) SHALL propagate; data registers of an invalid slot MAY hold any value, but out_valid SHALL be 0 for that slot.
REQ-019 In manual mode the effective select SHALL be sel as sampled on the accepting edge.
REQ-020 In scan mode the effective select SHALL be scan_cnt; scan_cnt SHALL increment by 1 on each edge where en=1 and in_valid=1, and SHALL wrap from N_IN-1 to 0.
REQ-021 A change of scan_mode SHALL affect only samples accepted on or after that edge; in-flight samples SHALL complete with their original select.
REQ-022 When scan_mode=0, scan_cnt SHALL hold its value; it SHALL NOT reset on mode change.
REQ-023 Throughput SHALL be one sample per cycle; there is no backpressure.

Reset
REQ-024 On rst_n=0, all valid bits, out_data, out_ch and scan_cnt SHALL clear to 0 immediately, regardless of clk.
REQ-025 Samples in flight at reset SHALL be discarded; out_valid SHALL stay 0 until LAT edges after the first accepted sample following release.

Configuration
REQ-026 Macro MUX_SCAN_EN: when defined, scan_cnt and the scan mode SHALL be implemented as in REQ-020 to REQ-022.
REQ-027 When MUX_SCAN_EN is undefined, the scan_mode port SHALL remain but be ignored, scan_cnt SHALL be absent, and sel SHALL always be used.

Structure
REQ-028 A shared package mux_pkg SHALL hold the legal-N_IN check function and the log4 depth function.
REQ-029 A sub-module mux4_stage (registered 4:1, data plus valid plus index side-band, en, async reset) SHALL be instantiated once per tree node, generated per level.

Verification
REQ-030 Setup N_IN=16, W=8, channel k=8'h10+k, en=1, manual mode; sel=0..15 on consecutive cycles -> out_data 8'h10..8'h1F and out_ch 0..15, starting 2 edges after the first sel, out_valid=1 throughout.
REQ-031 en=0 for 3 cycles mid-stream -> outputs frozen for 3 cycles, then the sequence resumes with no loss or duplication.
REQ-032 Scan mode (MUX_SCAN_EN defined), in_valid high for 18 cycles -> out_ch 0..15, 0, 1; in_valid low for 2 cycles mid-run -> counter holds and out_valid shows 2 bubbles.
REQ-033 Assert rst_n low between clock edges with 2 samples in flight -> outputs immediately 0; after release, out_valid=0 until 2 edges after the next accepted sample.
REQ-034 Switch scan_mode 1->0 with sel=5 while the pipeline is full -> in-flight scan indices complete, then out_ch=5 and out_data=8'h15.
REQ-035 N_IN=64, W=1, and N_IN=4, W=32 builds -> latency 3 and 1 respectively, with exhaustive select sweep correct.
